// File: rtl/xspi_phy_slave_os.sv
// Oversampled x1/x2/x4/x8 SPI slave PHY in the system clock domain.
// Ports: clk_i/rst_i; pad sck_i, sce_i, sio_i, sio_o, sio_oe;
//   descriptor txn_valid_i/txn_ready_o + txnbc_i, txnmode_i, txndir_i,
//   txndummy_i, txndata_i; results txndata_o, txndone_o,
//   txnabort_o, txnovr_o, busy_o.
module xspi_phy_slave_os #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int DUMMY_BITS       = 5,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sck_i,
  input  logic                        sce_i,
  input  logic [7:0]                  sio_i,
  output logic [7:0]                  sio_o,
  output logic                        sio_oe,
  input  logic                        txn_valid_i,
  output logic                        txn_ready_o,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic [DUMMY_BITS-1:0]       txndummy_i,
  input  logic [WORD_SIZE-1:0]        txndata_i,
  output logic [WORD_SIZE-1:0]        txndata_o,
  output logic                        txndone_o,
  output logic                        txnabort_o,
  output logic                        txnovr_o,
  output logic                        busy_o
);

  localparam int CW = CYCLE_COUNT_BITS + 1;
  localparam int PW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMMY,
    S_DATA
  } state_t;

  // pad synchronisers, equal depth on all three
  logic [SYNC_STAGES-1:0]      sck_sr;
  logic [SYNC_STAGES-1:0]      sce_sr;
  logic [SYNC_STAGES-1:0][7:0] sio_sr;
  logic                        sck_d;
  logic                        ce_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sr <= '0;
      sce_sr <= '0;
      sio_sr <= '0;
      sck_d  <= 1'b0;
      ce_d   <= 1'b0;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck_i};
      sce_sr <= {sce_sr[SYNC_STAGES-2:0], sce_i};
      sio_sr <= {sio_sr[SYNC_STAGES-2:0], sio_i};
      sck_d  <= sck_sr[SYNC_STAGES-1];
      ce_d   <= sce_sr[SYNC_STAGES-1];
    end
  end

  logic       sck_s;
  logic       ce;
  logic [7:0] sio_s;
  logic       rise;
  logic       fall;
  logic       ce_fall;

  assign sck_s   = sck_sr[SYNC_STAGES-1];
  assign ce      = sce_sr[SYNC_STAGES-1];
  assign sio_s   = sio_sr[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign ce_fall = ce_d & ~ce;

  // descriptor-derived values: cycle count and bit index of word 0
  logic [CW-1:0] bc_x;
  logic [CW-1:0] round_in;
  logic [CW-1:0] cyc_in;
  logic [PW-1:0] pos_in;

  assign bc_x     = {1'b0, txnbc_i};
  assign round_in = (CW'(1) << txnmode_i) - CW'(1);
  assign cyc_in   = (bc_x + round_in) >> txnmode_i;
  assign pos_in   = PW'(cyc_in - CW'(1)) << txnmode_i;

  state_t                  state;
  logic [1:0]              mode_q;
  logic                    dir_q;
  logic [DUMMY_BITS-1:0]   dummy_q;
  logic [CW-1:0]           cyc_q;
  logic [DUMMY_BITS-1:0]   dcnt;
  logic [CW-1:0]           ccnt;
  logic [PW-1:0]           pos_q;
  logic [WORD_SIZE-1:0]    data_q;

  logic [7:0]              lane_mask;
  logic [7:0]              word;
  logic [WORD_SIZE-1:0]    cap;

  always_comb begin
    lane_mask = 8'h01;
    cap       = {txndata_o[WORD_SIZE-2:0], sio_s[0]};
    unique case (mode_q)
      2'b00: begin
        lane_mask = 8'h01;
        cap = {txndata_o[WORD_SIZE-2:0], sio_s[0]};
      end
      2'b01: begin
        lane_mask = 8'h03;
        cap = {txndata_o[WORD_SIZE-3:0], sio_s[1:0]};
      end
      2'b10: begin
        lane_mask = 8'h0f;
        cap = {txndata_o[WORD_SIZE-5:0], sio_s[3:0]};
      end
      2'b11: begin
        lane_mask = 8'hff;
        cap = {txndata_o[WORD_SIZE-9:0], sio_s};
      end
    endcase
  end

  assign word = 8'(data_q >> pos_q) & lane_mask;

  logic abort_ok;
  assign abort_ok = (dcnt != '0) || (ccnt != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      dir_q      <= 1'b0;
      dummy_q    <= '0;
      cyc_q      <= '0;
      dcnt       <= '0;
      ccnt       <= '0;
      pos_q      <= '0;
      data_q     <= '0;
      txndata_o  <= '0;
      txndone_o  <= 1'b0;
      txnabort_o <= 1'b0;
      txnovr_o   <= 1'b0;
      sio_o      <= '0;
    end else begin
      txndone_o  <= 1'b0;
      txnabort_o <= 1'b0;
      txnovr_o   <= 1'b0;
      // registered so the word moves one clk after the fall is acted on
      sio_o      <= (state == S_DATA) ? word : 8'h00;
      unique case (state)
        S_IDLE: begin
          if (rise && ce)
            txnovr_o <= 1'b1;
          if (txn_valid_i) begin
            mode_q  <= txnmode_i;
            dir_q   <= txndir_i;
            dummy_q <= txndummy_i;
            cyc_q   <= cyc_in;
            pos_q   <= pos_in;
            data_q  <= txndata_i;
            dcnt    <= '0;
            ccnt    <= '0;
            state   <= (txndummy_i != '0) ? S_DUMMY : S_DATA;
          end
        end
        S_DUMMY: begin
          if (ce_fall) begin
            if (abort_ok) begin
              txnabort_o <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (rise && ce) begin
            dcnt <= dcnt + DUMMY_BITS'(1);
            if (dcnt + DUMMY_BITS'(1) == dummy_q)
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (ce_fall) begin
            if (abort_ok) begin
              txnabort_o <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (rise && ce) begin
            txndata_o <= cap;
            ccnt      <= ccnt + CW'(1);
            if (ccnt + CW'(1) == cyc_q) begin
              txndone_o <= 1'b1;
              state     <= S_IDLE;
            end
          end else if (fall && ce && ccnt != '0) begin
            pos_q <= pos_q - (PW'(1) << mode_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign txn_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign sio_oe      = ce && (state == S_DATA) && dir_q;

endmodule

// File: tb/tb_xspi_phy_slave_os.sv
// Directed bench for xspi_phy_slave_os.
// Host side modelled with SCK period of 16 clk.
module tb_xspi_phy_slave_os;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sck_i;
  logic        sce_i;
  logic [7:0]  sio_i;
  logic [7:0]  sio_o;
  logic        sio_oe;
  logic        txn_valid_i;
  logic        txn_ready_o;
  logic [5:0]  txnbc_i;
  logic [1:0]  txnmode_i;
  logic        txndir_i;
  logic [4:0]  txndummy_i;
  logic [31:0] txndata_i;
  logic [31:0] txndata_o;
  logic        txndone_o;
  logic        txnabort_o;
  logic        txnovr_o;
  logic        busy_o;

  xspi_phy_slave_os #(
    .WORD_SIZE(32),
    .CYCLE_COUNT_BITS(6),
    .DUMMY_BITS(5),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sck_i(sck_i),
    .sce_i(sce_i),
    .sio_i(sio_i),
    .sio_o(sio_o),
    .sio_oe(sio_oe),
    .txn_valid_i(txn_valid_i),
    .txn_ready_o(txn_ready_o),
    .txnbc_i(txnbc_i),
    .txnmode_i(txnmode_i),
    .txndir_i(txndir_i),
    .txndummy_i(txndummy_i),
    .txndata_i(txndata_i),
    .txndata_o(txndata_o),
    .txndone_o(txndone_o),
    .txnabort_o(txnabort_o),
    .txnovr_o(txnovr_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_abort = 0;
  int n_ovr = 0;

  always @(negedge clk_i) begin
    if (txndone_o)  n_done++;
    if (txnabort_o) n_abort++;
    if (txnovr_o)   n_ovr++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // one SCK period: low phase with data set up, then rise and sample
  task automatic sck_bit(input logic [7:0] d,
                         output logic [7:0] got,
                         output logic oe);
    sio_i = d;
    wait_clk(8);
    sck_i = 1'b1;
    got = sio_o;
    oe = sio_oe;
    wait_clk(8);
    sck_i = 1'b0;
  endtask

  task automatic send(input logic [5:0] bc, input logic [1:0] mode,
                      input logic dir, input logic [4:0] dm,
                      input logic [31:0] d);
    int n;
    @(negedge clk_i);
    txnbc_i = bc;
    txnmode_i = mode;
    txndir_i = dir;
    txndummy_i = dm;
    txndata_i = d;
    txn_valid_i = 1'b1;
    n = 0;
    while (!txn_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("desc_accept", txn_ready_o, 1);
    @(negedge clk_i);
    txn_valid_i = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  got;
    logic        oe;
    logic        oe_any;
    logic        oe_all;
    logic [31:0] rd;
    logic [3:0]  hi;
    logic [5:0]  rd6;
    logic [7:0]  v;
    logic [31:0] snap;
    int d0, a0, o0, n;

    rst_i = 1'b1;
    sck_i = 1'b0;
    sce_i = 1'b0;
    sio_i = 8'h00;
    txn_valid_i = 1'b0;
    txnbc_i = '0;
    txnmode_i = '0;
    txndir_i = 1'b0;
    txndummy_i = '0;
    txndata_i = '0;
    wait_clk(3);
    rst_i = 1'b0;
    wait_clk(2);
    check("rst_ctl", {txn_ready_o, busy_o, sio_oe,
                      txndone_o, txnabort_o, txnovr_o}, 6'b100000);
    check("rst_data", txndata_o, 0);
    check("rst_sio", sio_o, 0);
    sce_i = 1'b1;
    wait_clk(4);

    // single-lane write of 0xA5
    d0 = n_done;
    oe_any = 1'b0;
    v = 8'hA5;
    send(6'd8, 2'b00, 1'b0, 5'd0, 32'h0);
    check("t1_busy", busy_o, 1);
    for (int i = 0; i < 8; i++) begin
      sck_bit({7'b0, v[7-i]}, got, oe);
      oe_any |= oe;
    end
    wait_clk(4);
    check("t1_data", txndata_o[7:0], 8'hA5);
    check("t1_done", n_done - d0, 1);
    check("t1_oe", oe_any, 0);

    // quad read with 4 dummy cycles
    d0 = n_done;
    send(6'd32, 2'b10, 1'b1, 5'd4, 32'hDEADBEEF);
    oe_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sck_bit(8'h00, got, oe);
      oe_any |= oe;
    end
    check("t2_dummy_oe", oe_any, 0);
    rd = '0;
    hi = '0;
    oe_all = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sck_bit(8'h00, got, oe);
      rd = {rd[27:0], got[3:0]};
      hi |= got[7:4];
      oe_all &= oe;
    end
    wait_clk(4);
    check("t2_read", rd, 32'hDEADBEEF);
    check("t2_unused_lanes", hi, 0);
    check("t2_oe_data", oe_all, 1);
    check("t2_done", n_done - d0, 1);
    check("t2_oe_idle", sio_oe, 0);

    // ce drop with both counters zero keeps the descriptor
    d0 = n_done;
    a0 = n_abort;
    send(6'd8, 2'b00, 1'b0, 5'd0, 32'h0);
    sce_i = 1'b0;
    wait_clk(6);
    sce_i = 1'b1;
    wait_clk(6);
    check("t3_kept_busy", busy_o, 1);
    check("t3_no_abort", n_abort - a0, 0);
    v = 8'h5A;
    for (int i = 0; i < 8; i++)
      sck_bit({7'b0, v[7-i]}, got, oe);
    wait_clk(4);
    check("t3_data", txndata_o[7:0], 8'h5A);
    check("t3_done", n_done - d0, 1);

    // dual-lane read/write with odd bit count
    d0 = n_done;
    send(6'd5, 2'b01, 1'b1, 5'd0, 32'h15);
    rd6 = '0;
    for (int i = 0; i < 3; i++) begin
      sck_bit(8'h01, got, oe);
      rd6 = {rd6[3:0], got[1:0]};
    end
    wait_clk(4);
    check("t4_drive", rd6, 6'b010101);
    check("t4_data", txndata_o[5:0], 6'h15);
    check("t4_done", n_done - d0, 1);

    // abort after 3 rises
    d0 = n_done;
    a0 = n_abort;
    send(6'd8, 2'b00, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++)
      sck_bit(8'h01, got, oe);
    sce_i = 1'b0;
    n = 0;
    while (!txnabort_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("t5_abort_pulse", txnabort_o, 1);
    wait_clk(1);
    check("t5_ready", txn_ready_o, 1);
    check("t5_busy", busy_o, 0);
    wait_clk(3);
    check("t5_abort_cnt", n_abort - a0, 1);
    check("t5_no_done", n_done - d0, 0);
    sce_i = 1'b1;
    wait_clk(4);

    // overrun: rises with no descriptor
    o0 = n_ovr;
    snap = txndata_o;
    sck_bit(8'hFF, got, oe);
    sck_bit(8'hFF, got, oe);
    wait_clk(4);
    check("t6_ovr", n_ovr - o0, 2);
    check("t6_data_kept", txndata_o, snap);
    check("t6_busy", busy_o, 0);

    // reset mid octo read, then octo write
    send(6'd32, 2'b11, 1'b1, 5'd0, 32'h12345678);
    sck_bit(8'h00, got, oe);
    check("t7_byte0", got, 8'h12);
    sck_bit(8'h00, got, oe);
    check("t7_byte1", got, 8'h34);
    wait_clk(2);
    rst_i = 1'b1;
    wait_clk(2);
    check("t7_rst_ctl", {txn_ready_o, busy_o, sio_oe,
                         txndone_o, txnabort_o, txnovr_o}, 6'b100000);
    check("t7_rst_data", txndata_o, 0);
    check("t7_rst_sio", sio_o, 0);
    rst_i = 1'b0;
    wait_clk(4);
    d0 = n_done;
    send(6'd8, 2'b11, 1'b0, 5'd0, 32'h0);
    sck_bit(8'h3C, got, oe);
    wait_clk(4);
    check("t7_octo_data", txndata_o[7:0], 8'h3C);
    check("t7_octo_done", n_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
